knn_vote: RTL and testbench
===========================

Name: knn_vote

Overview:
- Consumer end of the distance-sort pipeline: accepts the ascending-sorted stream of (distance, type) pairs that the compare-exchange network produces.
- Keeps the first K pairs (the K nearest neighbours) and counts votes per type in a histogram.
- When the list ends, scans the histogram and emits the winning class with its vote count.
- Sits between the sorter output and the classification result register.

Parameters:
- W, 16, distance width (matches the sorter).
- TYPE_W, 3, class/type label width.
- K, 5, neighbours counted; legal range 1..255.
- N_TYPES, 2**TYPE_W, number of histogram bins.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_dist  in  W  distance of the pair; stream is ascending.
- in_type  in  TYPE_W  class label of the pair.
- in_last  in  1  marks the final pair of the sorted list.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_type  out  TYPE_W  winning class.
- out_votes  out  $clog2(K+1)  votes for the winning class.
- out_nearest  out  W  distance of the first accepted pair (nearest neighbour).

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_type=0, out_votes=0, out_nearest=0. All histogram bins, the rank counter and the state are cleared; state goes to CLEAR.
- Reset mid-operation discards any partial list; no result is emitted for it.
- A transfer occurs on any cycle with in_valid && in_ready.

States:
- CLEAR: zeroes one histogram bin per cycle over N_TYPES cycles; in_ready=0. Then goes to ACCUM.
- ACCUM: in_ready=1.
  - rank counts accepted pairs, 0-based.
  - If rank<K, increment hist[in_type].
  - If rank==0, capture in_dist into out_nearest.
  - Pairs with rank>=K are accepted and dropped.
  - rank saturates at K.
  - A transfer with in_last=1 goes to VOTE.
- VOTE: in_ready=0. Scans bins 0..N_TYPES-1, one per cycle.
  - Holds best_type and best_cnt; replaces them only on a strictly greater count, so ties go to the lowest index.
  - After the last bin, loads out_type/out_votes and goes to OUT.
- OUT: out_valid=1, with out_type, out_votes and out_nearest held stable until out_ready. Handshake goes to CLEAR and out_valid drops the next cycle.

Latency and boundaries:
- Latency from the in_last transfer to out_valid is N_TYPES+1 cycles.
- Throughput is one list per (list length + 2*N_TYPES + 2) cycles, at minimum.
- List shorter than K (in_last at rank<K): vote over the received pairs only; out_votes can be less than K.
- Single-pair list (in_last on the first transfer): that type wins with out_votes=1.
- K=1: winner is the type of the first pair.
- All bins zero cannot occur, because every list holds at least one pair.
- Bin counters are $clog2(K+1) bits wide and cannot overflow, because at most K increments happen per list.
- The block does not check that distances arrive in ascending order.
- in_valid is ignored outside ACCUM.
- out_ready is ignored outside OUT.

Optional Feature:
- KNN_VOTE_NEAREST_TIE_EN defined:
  - Each bin also stores first_rank, the rank at which its type was first counted; the value K means "unset".
  - In VOTE, on an equal count, the bin with the smaller first_rank wins, so ties go to the class of the nearer neighbour.
  - first_rank is cleared to K in CLEAR.
- Not defined: no first_rank storage; ties go to the lowest type index.

Decomposition:
- Shared package knn_pkg holds:
  - default W and TYPE_W constants, shared with sort_2;
  - the state enum {CLEAR, ACCUM, VOTE, OUT};
  - a vote-count width function, cnt_w(K) = $clog2(K+1).
- One sub-module, knn_argmax_scan: the sequential bin scanner with start, bin index, count and first_rank inputs, and done, best_type and best_cnt outputs.

Test Plan:
- K=5, pairs (types 2,2,1,3,2,1,1) with in_last on the 7th → out_type=2, out_votes=3; out_nearest equals the first distance; the 6th and 7th pairs are ignored.
- Tie without the macro: K=4, types (3,1,3,1) → out_type=1, out_votes=2. With KNN_VOTE_NEAREST_TIE_EN: out_type=3.
- Short list: K=5, a single pair, type 6, dist 0x0042, in_last=1 → out_type=6, out_votes=1, out_nearest=0x0042; out_valid rises exactly N_TYPES+1 cycles later.
- Backpressure: hold out_ready=0 for 10 cycles → outputs stable, in_ready=0 throughout. Release → next list accepted after the N_TYPES clear cycles, and results do not leak from the previous list.
- Reset mid-ACCUM after 3 pairs → all outputs return to their reset values, no out_valid; a subsequent list is voted as if fresh.
- Random lists of 1..20 pairs, 200 iterations, with random in_valid and out_ready gaps → result matches a reference-model vote on the first K pairs.

Source files
------------

// File: rtl/knn_pkg.sv
// knn_pkg: shared widths, vote-FSM states and count-width helper for the distance-sort pipeline
package knn_pkg;
  localparam int W_DEF = 16;
  localparam int TYPE_W_DEF = 3;
  typedef enum logic [1:0] {CLEAR, ACCUM, VOTE, OUT} state_t;
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction
endpackage

// File: rtl/knn_argmax_scan.sv
// knn_argmax_scan: sequential argmax over histogram bins; KNN_VOTE_NEAREST_TIE_EN breaks ties by first_rank
module knn_argmax_scan
  import knn_pkg::*;
#(
  parameter int TYPE_W = TYPE_W_DEF,
  parameter int K = 5,
  parameter int N_TYPES = 2 ** TYPE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TYPE_W-1:0]     bin_idx,
  input  logic [cnt_w(K)-1:0]   cnt,
  input  logic [cnt_w(K)-1:0]   first_rank,
  output logic                  done,
  output logic [TYPE_W-1:0]     best_type,
  output logic [cnt_w(K)-1:0]   best_cnt
);
  localparam int CW = cnt_w(K);
  logic run, act, better, last;
  assign act = start | run;
  assign last = bin_idx == TYPE_W'(N_TYPES - 1);
`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [CW-1:0] best_fr;
  assign better = start || cnt > best_cnt || (cnt == best_cnt && first_rank < best_fr);
  always_ff @(posedge clk)
    if (rst) best_fr <= CW'(K);
    else if (act && better) best_fr <= first_rank;
`else
  logic unused_fr;
  assign unused_fr = ^first_rank;
  assign better = start || cnt > best_cnt;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      done <= 1'b0;
      best_type <= '0;
      best_cnt <= '0;
    end else begin
      run <= act && !last;
      done <= act && last;
      if (act && better) begin
        best_type <= bin_idx;
        best_cnt <= cnt;
      end
    end
  end
endmodule

// File: rtl/knn_vote.sv
// knn_vote: K-nearest-neighbour majority vote over a sorted stream; KNN_VOTE_NEAREST_TIE_EN favours the nearer class on ties
module knn_vote
  import knn_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int TYPE_W = TYPE_W_DEF,
  parameter int K = 5,
  parameter int N_TYPES = 2 ** TYPE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_dist,
  input  logic [TYPE_W-1:0]     in_type,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TYPE_W-1:0]     out_type,
  output logic [cnt_w(K)-1:0]   out_votes,
  output logic [W-1:0]          out_nearest
);
  localparam int CW = cnt_w(K);
  localparam int IW = $clog2(N_TYPES) + 1;
  localparam logic [CW-1:0] KC = CW'(K);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [TYPE_W-1:0] bi, best_type;
  logic [CW-1:0] rank, best_cnt, fr_rd;
  logic [CW-1:0] hist [N_TYPES];
  logic xfer, start, done, last_bin;
  assign bi = idx[TYPE_W-1:0];
  assign in_ready = state == ACCUM;
  assign out_valid = state == OUT;
  assign xfer = in_valid && in_ready;
  assign start = state == VOTE && idx == '0;
  assign last_bin = idx == IW'(N_TYPES - 1);
  always_comb begin
    state_n = state;
    state_n = state == CLEAR ? (last_bin ? ACCUM : CLEAR) :
              state == ACCUM ? (xfer && in_last ? VOTE : ACCUM) :
              state == VOTE  ? (done ? OUT : VOTE) :
                               (out_ready ? CLEAR : OUT);
  end
  always_ff @(posedge clk)
    if (rst) state <= CLEAR;
    else state <= state_n;
`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [CW-1:0] fr [N_TYPES];
  assign fr_rd = fr[bi];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TYPES; i++) fr[i] <= KC;
    end else begin
      if (state == CLEAR) fr[bi] <= KC;
      if (xfer && rank < KC && fr[in_type] == KC) fr[in_type] <= rank;
    end
  end
`else
  assign fr_rd = KC;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      rank <= '0;
      out_type <= '0;
      out_votes <= '0;
      out_nearest <= '0;
      for (int i = 0; i < N_TYPES; i++) hist[i] <= '0;
    end else begin
      idx <= (state == CLEAR && !last_bin) || (state == VOTE && !done) ? idx + 1'b1 : '0;
      if (state == CLEAR) begin
        hist[bi] <= '0;
        rank <= '0;
      end
      if (xfer) begin
        if (rank < KC) hist[in_type] <= hist[in_type] + 1'b1;
        if (rank == '0) out_nearest <= in_dist;
        if (rank != KC) rank <= rank + 1'b1;
      end
      if (state == VOTE && done) begin
        out_type <= best_type;
        out_votes <= best_cnt;
      end
    end
  end
  knn_argmax_scan #(.TYPE_W(TYPE_W), .K(K), .N_TYPES(N_TYPES)) u_scan (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin_idx(bi),
    .cnt(hist[bi]),
    .first_rank(fr_rd),
    .done(done),
    .best_type(best_type),
    .best_cnt(best_cnt)
  );
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: scoreboard bench for knn_vote with directed lists and reference-model random lists
module tb_knn_vote;
  import knn_pkg::*;
  localparam int K = 5;
  localparam int NT = 8;
`ifdef KNN_VOTE_NEAREST_TIE_EN
  localparam bit TIE = 1'b1;
`else
  localparam bit TIE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_dist = '0;
  logic [2:0] in_type = '0;
  logic out_valid, out_ready = 1'b0;
  logic [2:0] out_type;
  logic [cnt_w(K)-1:0] out_votes;
  logic [15:0] out_nearest;
  always #5 clk = ~clk;
  knn_vote #(.W(16), .TYPE_W(3), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dist(in_dist), .in_type(in_type), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_votes(out_votes), .out_nearest(out_nearest)
  );
  typedef struct packed {
    logic [2:0] t;
    logic [2:0] v;
    logic [15:0] n;
  } exp_t;
  exp_t sb[$];
  exp_t em;
  int cmp = 0, bad = 0, rdy_mode = 0;
  int lt[$];
  logic [15:0] ld[$];
  function automatic exp_t mk(input int t, input int v, input int n);
    mk.t = 3'(t);
    mk.v = 3'(v);
    mk.n = 16'(n);
  endfunction
  function automatic exp_t model();
    int c[NT], f[NT], b;
    for (int i = 0; i < NT; i++) begin c[i] = 0; f[i] = K; end
    for (int r = 0; r < lt.size() && r < K; r++) begin
      if (f[lt[r]] == K) f[lt[r]] = r;
      c[lt[r]]++;
    end
    b = 0;
    for (int i = 1; i < NT; i++)
      if (c[i] > c[b] || (TIE && c[i] == c[b] && f[i] < f[b])) b = i;
    return mk(b, c[b], ld[0]);
  endfunction
  task automatic chk(input string nm, input int a, input int e);
    cmp++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  task automatic send(input bit last_en, input int gap, input exp_t e, input bit push);
    int w;
    if (push) sb.push_back(e);
    for (int i = 0; i < lt.size(); i++) begin
      w = 0;
      do begin
        @(negedge clk);
        in_valid = $urandom_range(0, 99) >= gap;
        in_type = 3'(lt[i]);
        in_dist = ld[i];
        in_last = last_en && i == lt.size() - 1;
        w++;
      end while (!(in_valid && in_ready) && w < 400);
      if (!(in_valid && in_ready)) chk("send_timeout", w, 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1 out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        em = sb.pop_front();
        chk("out_type", out_type, em.t);
        chk("out_votes", out_votes, em.v);
        chk("out_nearest", out_nearest, em.n);
      end
    end
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, seen;
    logic [15:0] d;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_type", out_type, 0);
    chk("rst_out_votes", out_votes, 0);
    chk("rst_out_nearest", out_nearest, 0);
    rst = 1'b0;
    lt = '{2, 2, 1, 3, 2, 1, 1};
    ld = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70};
    send(1, 0, mk(2, 3, 10), 1);
    drain();
    lt = '{3, 1, 3, 1};
    ld = '{16'd5, 16'd6, 16'd7, 16'd8};
    send(1, 30, mk(TIE ? 3 : 1, 2, 5), 1);
    drain();
    lt = '{6};
    ld = '{16'h0042};
    send(1, 0, mk(6, 1, 16'h42), 1);
    n = 0;
    do begin @(posedge clk); #1 n++; end while (!out_valid && n < 50);
    chk("latency", n, NT + 1);
    drain();
    rdy_mode = 2;
    lt = '{4, 4, 0, 4};
    ld = '{16'd3, 16'd4, 16'd5, 16'd6};
    send(1, 0, mk(4, 3, 3), 1);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", out_valid, 1);
    in_valid = 1'b1;
    in_type = 3'd7;
    in_dist = 16'hffff;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_type", out_type, 4);
      chk("bp_out_votes", out_votes, 3);
      chk("bp_out_nearest", out_nearest, 3);
      chk("bp_in_ready", in_ready, 0);
    end
    rdy_mode = 0;
    lt = '{5, 0, 0};
    ld = '{16'd100, 16'd200, 16'd300};
    send(1, 0, mk(0, 2, 100), 1);
    drain();
    lt = '{7, 7, 7};
    ld = '{16'd1, 16'd2, 16'd3};
    send(0, 0, mk(0, 0, 0), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_type", out_type, 0);
    chk("mid_rst_out_votes", out_votes, 0);
    chk("mid_rst_out_nearest", out_nearest, 0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); seen |= int'(out_valid); end
    chk("no_out_after_rst", seen, 0);
    lt = '{1, 7};
    ld = '{16'd9, 16'd10};
    send(1, 0, mk(1, 1, 9), 1);
    drain();
    rdy_mode = 1;
    for (int it = 0; it < 200; it++) begin
      lt.delete();
      ld.delete();
      n = $urandom_range(1, 20);
      d = 16'($urandom_range(0, 50));
      for (int i = 0; i < n; i++) begin
        lt.push_back($urandom_range(0, NT - 1));
        ld.push_back(d);
        d = d + 16'($urandom_range(0, 100));
      end
      send(1, 25, model(), 1);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
